dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory (dm) between requester 0 (CPU load/store stage) and requester 1 (DMA/debug port).
- Uses a req/gnt/rvalid handshake per requester and sequences exactly one dm access at a time.
- Drives dm's addr/invalue/memwrite/memread and returns dm's outvalue to the winning requester.

Parameters:
- ADDR_W, 32, width of request and dm addresses.
- DATA_W, 32, width of write/read data.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 access request; held with payload until r0_gnt.
- r0_we  in  1  requester 0: 1 = write, 0 = read.
- r0_addr  in  ADDR_W  requester 0 byte address.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_gnt  out  1  requester 0 grant pulse (combinational, IDLE only).
- r0_rvalid  out  1  requester 0 completion pulse (registered).
- r0_rdata  out  DATA_W  requester 0 read data, valid with r0_rvalid.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1.
- dm_addr  out  ADDR_W  to dm addr.
- dm_invalue  out  DATA_W  to dm invalue.
- dm_memwrite  out  1  to dm memwrite.
- dm_memread  out  1  to dm memread.
- dm_outvalue  in  DATA_W  from dm outvalue; combinational read data.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (reset=0) forces IDLE asynchronously.
- Reset values: all gnt/rvalid = 0; rdata = 0; dm_addr/dm_invalue = 0; dm_memwrite/dm_memread = 0; latched payload = 0; last_winner = 1.
- IDLE:
  - If any req is high, select a winner and assert its gnt combinationally in that cycle.
  - On the clock edge, latch the winner's we/addr/wdata and winner id, then go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (exactly one cycle):
  - dm_addr = latched addr; dm_invalue = latched wdata.
  - dm_memwrite = latched we; dm_memread = ~latched we.
  - The write commits in dm on the closing edge.
  - For a read, dm_outvalue is captured into the winner's rdata register on the closing edge.
  - Next state is RESP.
- RESP (one cycle):
  - The winner's rvalid = 1. The other rvalid stays 0.
  - For a write, rvalid is the write acknowledge and rdata holds its previous value.
  - Next state is IDLE. No grant is issued in RESP.
- dm_memwrite and dm_memread are 0 in every state except ACCESS. dm_addr and dm_invalue hold their last values outside ACCESS.
- Latency: gnt in cycle N, dm access in N+1, rvalid in N+2. Maximum throughput is one access per 3 cycles.
- Boundaries:
  - req dropped before gnt: no access is performed and no state change occurs.
  - req held after gnt: ignored until the FSM returns to IDLE; the requester must deassert or re-request.
  - Both req high in IDLE: winner chosen by the arbitration policy (Optional Feature). last_winner updates only on a grant.
  - Address passes through unmodified, with no alignment check.
  - Reset asserted mid-ACCESS: dm_memwrite drops to 0 asynchronously, the write is not committed, and no rvalid is issued.
  - Reset asserted mid-RESP: rvalid drops immediately.

Optional Feature:
- Macro: DMARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On simultaneous requests, the requester that is not last_winner wins. After reset, r0 wins first.
- Undefined: fixed priority. r0 always wins simultaneous requests. last_winner is still maintained but unused.

Test Plan:
- r0 write addr=0x10, wdata=0xDEADBEEF, then r0 read 0x10 -> r0_gnt in IDLE cycle; dm_memwrite=1 for exactly 1 cycle with dm_addr=0x10; second access gives r0_rvalid with r0_rdata=0xDEADBEEF, 2 cycles after gnt.
- r1 read of 0x20 (preloaded 0x12345678) while r0 idle -> r1_rvalid=1 with r1_rdata=0x12345678; r0_rvalid stays 0; dm_memread=1 only in the ACCESS cycle.
- r0 and r1 both hold req continuously for 4 grants:
  - with DMARB_ROUND_ROBIN_EN -> grant order r0, r1, r0, r1;
  - without it -> r0, r0, r0, r0.
- r1_req pulsed for 1 cycle while the FSM is in ACCESS for r0 -> no r1 grant or access; dm sees only r0's transaction.
- Assert reset (0) during ACCESS of r0 write 0x55 to addr 0x30 -> dm_memwrite=0 immediately; a subsequent read of 0x30 returns its prior value; all outputs are at reset values.
- After reset, with no requests for 10 cycles -> all gnt/rvalid/dm_memwrite/dm_memread remain 0.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester handshakes and dm port bundle shared by dm_arbiter and its environment.
//   slave  : arbiter side - takes r*_req/we/addr/wdata and dm_outvalue,
//            drives r*_gnt/rvalid/rdata and dm_addr/invalue/memwrite/memread
//   master : environment side (requesters plus the data memory), opposite directions
interface dm_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata, r0_rdata;
   logic              r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata, r1_rdata;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_invalue, dm_outvalue;
   logic              dm_memwrite, dm_memread;
   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, dm_outvalue,
      output r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
             dm_addr, dm_invalue, dm_memwrite, dm_memread
   );
   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, dm_outvalue,
      input  r0_gnt, r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata,
             dm_addr, dm_invalue, dm_memwrite, dm_memread
   );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-port data memory between requester 0 (CPU) and requester 1 (DMA/debug).
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dm_arbiter_if.slave - per-requester req/gnt/rvalid handshake and the dm port
// One access at a time: gnt (IDLE, combinational) -> dm access (ACCESS) -> rvalid (RESP).
// Optional macro DMARB_ROUND_ROBIN_EN: round-robin on ties; otherwise r0 has fixed priority.
module dm_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic         clk,
   input logic         reset,
   dm_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
   state_e            state_q, state_d;
   logic              we_q, we_d, win_q, win_d, last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              idle, any_req, pick1;
   assign idle    = state_q == IDLE;
   assign any_req = bus.r0_req | bus.r1_req;
`ifdef DMARB_ROUND_ROBIN_EN
   // on a tie the requester that did not win last time goes first
   assign pick1 = bus.r1_req & (~bus.r0_req | ~last_q);
`else
   assign pick1 = bus.r1_req & ~bus.r0_req;
`endif
   assign bus.r0_gnt      = idle & any_req & ~pick1;
   assign bus.r1_gnt      = idle & pick1;
   assign bus.r0_rvalid   = (state_q == RESP) & ~win_q;
   assign bus.r1_rvalid   = (state_q == RESP) & win_q;
   assign bus.r0_rdata    = rdata0_q;
   assign bus.r1_rdata    = rdata1_q;
   // latched payload only changes on a grant, so dm_addr/invalue hold outside ACCESS
   assign bus.dm_addr     = addr_q;
   assign bus.dm_invalue  = wdata_q;
   assign bus.dm_memwrite = (state_q == ACCESS) & we_q;
   assign bus.dm_memread  = (state_q == ACCESS) & ~we_q;
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      win_d    = win_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      case (state_q)
         IDLE: if (any_req) begin
            state_d = ACCESS;
            win_d   = pick1;
            last_d  = pick1;
            we_d    = pick1 ? bus.r1_we : bus.r0_we;
            addr_d  = pick1 ? bus.r1_addr : bus.r0_addr;
            wdata_d = pick1 ? bus.r1_wdata : bus.r0_wdata;
         end
         ACCESS: begin
            state_d  = RESP;
            rdata0_d = (!we_q && !win_q) ? bus.dm_outvalue : rdata0_q;
            rdata1_d = (!we_q && win_q) ? bus.dm_outvalue : rdata1_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         win_q    <= 1'b0;
         last_q   <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         win_q    <= win_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed self-checking bench for dm_arbiter against a transaction-level model.
module tb_dm_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   dm_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
   logic [31:0] mem [0:255] = '{default: '0};
   assign bus.dm_outvalue = mem[bus.dm_addr[7:0]];
   always @(posedge clk) if (bus.dm_memwrite) mem[bus.dm_addr[7:0]] <= bus.dm_invalue;
   logic [31:0] mdl [0:255] = '{default: '0};
   logic [31:0] rd_exp [2] = '{32'h0, 32'h0};
   bit last_w = 1'b1;
   int total = 0;
   int bad = 0;
   logic o_g0, o_g1, o_mw, o_mr, o_rv0, o_rv1, o_q;
   logic [31:0] o_addr, o_din, o_rd0, o_rd1, o_addr2;
   function automatic bit pick(input bit q0, input bit q1);
      if (!(q0 && q1)) return q1;
`ifdef DMARB_ROUND_ROBIN_EN
      return !last_w;
`else
      return 1'b0;
`endif
   endfunction
   task automatic mdl_do(input bit w, input bit we, input logic [31:0] a, input logic [31:0] d);
      last_w = w;
      if (we) mdl[a[7:0]] = d;
      else rd_exp[w] = mdl[a[7:0]];
   endtask
   task automatic mdl_reset();
      rd_exp = '{32'h0, 32'h0};
      last_w = 1'b1;
   endtask
   task automatic drive(input bit q0, input bit q1, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit we1, input logic [31:0] a1, input logic [31:0] d1);
      bus.r0_req = q0; bus.r0_we = we0; bus.r0_addr = a0; bus.r0_wdata = d0;
      bus.r1_req = q1; bus.r1_we = we1; bus.r1_addr = a1; bus.r1_wdata = d1;
   endtask
   task automatic run(input bit drop);
      @(negedge clk);
      o_g0 = bus.r0_gnt; o_g1 = bus.r1_gnt; o_q = bus.dm_memwrite | bus.dm_memread | bus.r0_rvalid | bus.r1_rvalid;
      @(posedge clk); #1;
      if (drop) begin bus.r0_req = 1'b0; bus.r1_req = 1'b0; end
      @(negedge clk);
      o_mw = bus.dm_memwrite; o_mr = bus.dm_memread; o_addr = bus.dm_addr; o_din = bus.dm_invalue;
      o_q = o_q | bus.r0_gnt | bus.r1_gnt | bus.r0_rvalid | bus.r1_rvalid;
      @(posedge clk); #1;
      @(negedge clk);
      o_rv0 = bus.r0_rvalid; o_rv1 = bus.r1_rvalid; o_rd0 = bus.r0_rdata; o_rd1 = bus.r1_rdata; o_addr2 = bus.dm_addr;
      o_q = o_q | bus.r0_gnt | bus.r1_gnt | bus.dm_memwrite | bus.dm_memread;
      @(posedge clk); #1;
   endtask
   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      total++; if ({bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.dm_memwrite, bus.dm_memread} !== 6'b0) begin bad++; $display("FAIL rst_ctrl got=%b exp=000000", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.dm_memwrite, bus.dm_memread}); end
      total++; if ({bus.r0_rdata, bus.r1_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {bus.r0_rdata, bus.r1_rdata}); end
      total++; if ({bus.dm_addr, bus.dm_invalue} !== 64'h0) begin bad++; $display("FAIL rst_dm got=%h exp=0", {bus.dm_addr, bus.dm_invalue}); end
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask
   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++; if ({bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.dm_memwrite, bus.dm_memread} !== 6'b0) begin bad++; $display("FAIL idle_quiet cyc=%0d got=%b exp=000000", i, {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.dm_memwrite, bus.dm_memread}); end
      end
      @(posedge clk); #1;
   endtask
   task automatic test_write_read();
      drive(1, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0);
      run(1);
      mdl_do(0, 1, 32'h10, 32'hDEADBEEF);
      total++; if ({o_g1, o_g0} !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", {o_g1, o_g0}); end
      total++; if ({o_mw, o_mr, o_addr, o_din} !== {2'b10, 32'h10, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_access got=%b%b %h %h exp=10 00000010 deadbeef", o_mw, o_mr, o_addr, o_din); end
      total++; if ({o_rv1, o_rv0, o_q} !== 3'b010) begin bad++; $display("FAIL wr_resp got=%b exp=010", {o_rv1, o_rv0, o_q}); end
      drive(1, 0, 0, 32'h10, 32'h0, 0, 0, 0);
      run(1);
      mdl_do(0, 0, 32'h10, 32'h0);
      total++; if ({o_mw, o_mr, o_addr} !== {2'b01, 32'h10}) begin bad++; $display("FAIL rd_access got=%b%b %h exp=01 00000010", o_mw, o_mr, o_addr); end
      total++; if ({o_rv1, o_rv0, o_rd0} !== {2'b01, 32'hDEADBEEF}) begin bad++; $display("FAIL rd_resp got=%b%b %h exp=01 deadbeef", o_rv1, o_rv0, o_rd0); end
   endtask
   task automatic test_r1_read();
      drive(0, 1, 0, 0, 0, 1, 32'h20, 32'h12345678);
      run(1);
      mdl_do(1, 1, 32'h20, 32'h12345678);
      drive(0, 1, 0, 0, 0, 0, 32'h20, 32'h0);
      run(1);
      mdl_do(1, 0, 32'h20, 32'h0);
      total++; if ({o_g1, o_g0} !== 2'b10) begin bad++; $display("FAIL r1_gnt got=%b exp=10", {o_g1, o_g0}); end
      total++; if ({o_mw, o_mr, o_q} !== 3'b010) begin bad++; $display("FAIL r1_memread got=%b exp=010", {o_mw, o_mr, o_q}); end
      total++; if ({o_rv1, o_rv0, o_rd1} !== {2'b10, 32'h12345678}) begin bad++; $display("FAIL r1_resp got=%b%b %h exp=10 12345678", o_rv1, o_rv0, o_rd1); end
   endtask
   task automatic test_held();
      bit w;
      drive(1, 1, 0, 32'h40, 32'h0, 0, 32'h44, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         w = pick(1, 1);
         total++; if ({bus.r1_gnt, bus.r0_gnt} !== (w ? 2'b10 : 2'b01)) begin bad++; $display("FAIL held_gnt n=%0d got=%b exp_winner=%0d", i, {bus.r1_gnt, bus.r0_gnt}, w); end
         mdl_do(w, 0, w ? 32'h44 : 32'h40, 32'h0);
         @(posedge clk); #1;
         @(posedge clk); #1;
         @(negedge clk);
         total++; if ({bus.r1_rvalid, bus.r0_rvalid} !== (w ? 2'b10 : 2'b01)) begin bad++; $display("FAIL held_rvalid n=%0d got=%b exp_winner=%0d", i, {bus.r1_rvalid, bus.r0_rvalid}, w); end
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic test_pulse();
      drive(1, 0, 0, 32'h10, 32'h0, 0, 0, 0);
      @(negedge clk);
      total++; if ({bus.r1_gnt, bus.r0_gnt} !== 2'b01) begin bad++; $display("FAIL pulse_gnt got=%b exp=01", {bus.r1_gnt, bus.r0_gnt}); end
      @(posedge clk); #1;
      drive(0, 1, 0, 0, 0, 1, 32'h10, 32'h00000BAD);
      @(negedge clk);
      total++; if ({bus.r1_gnt, bus.dm_memwrite, bus.dm_memread, bus.dm_addr} !== {3'b001, 32'h10}) begin bad++; $display("FAIL pulse_access got=%b %h exp=001 00000010", {bus.r1_gnt, bus.dm_memwrite, bus.dm_memread}, bus.dm_addr); end
      @(posedge clk); #1;
      bus.r1_req = 1'b0;
      mdl_do(0, 0, 32'h10, 32'h0);
      @(negedge clk);
      total++; if ({bus.r1_rvalid, bus.r0_rvalid, bus.r0_rdata} !== {2'b01, rd_exp[0]}) begin bad++; $display("FAIL pulse_resp got=%b %h exp=01 %h", {bus.r1_rvalid, bus.r0_rvalid}, bus.r0_rdata, rd_exp[0]); end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         total++; if ({bus.r0_gnt, bus.r1_gnt, bus.dm_memwrite, bus.dm_memread} !== 4'b0) begin bad++; $display("FAIL pulse_after cyc=%0d got=%b exp=0000", i, {bus.r0_gnt, bus.r1_gnt, bus.dm_memwrite, bus.dm_memread}); end
      end
      @(posedge clk); #1;
   endtask
   task automatic test_random(input int n);
      bit q0, q1, we0, we1, w, ew;
      logic [31:0] a0, a1, d0, d1, ea, ed;
      for (int i = 0; i < n; i++) begin
         q0 = 1'($urandom_range(0, 1)); q1 = 1'($urandom_range(0, 1));
         if (!q0 && !q1) q1 = 1'b1;
         we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
         a0 = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 7) * 4);
         a1 = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 7) * 4);
         d0 = $urandom; d1 = $urandom;
         drive(q0, q1, we0, a0, d0, we1, a1, d1);
         w = pick(q0, q1);
         ew = w ? we1 : we0; ea = w ? a1 : a0; ed = w ? d1 : d0;
         run(1);
         mdl_do(w, ew, ea, ed);
         total++; if ({o_g1, o_g0} !== (w ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rnd_gnt i=%0d got=%b exp_winner=%0d", i, {o_g1, o_g0}, w); end
         total++; if ({o_mw, o_mr} !== {ew, !ew}) begin bad++; $display("FAIL rnd_ctrl i=%0d got=%b%b exp=%b%b", i, o_mw, o_mr, ew, !ew); end
         total++; if ({o_addr, o_din, o_addr2} !== {ea, ed, ea}) begin bad++; $display("FAIL rnd_dm i=%0d got=%h %h %h exp=%h %h %h", i, o_addr, o_din, o_addr2, ea, ed, ea); end
         total++; if ({o_rv1, o_rv0, o_q} !== (w ? 3'b100 : 3'b010)) begin bad++; $display("FAIL rnd_resp i=%0d got=%b exp_winner=%0d", i, {o_rv1, o_rv0, o_q}, w); end
         total++; if ({o_rd0, o_rd1} !== {rd_exp[0], rd_exp[1]}) begin bad++; $display("FAIL rnd_rdata i=%0d got=%h %h exp=%h %h", i, o_rd0, o_rd1, rd_exp[0], rd_exp[1]); end
         drive(0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask
   task automatic test_reset_access();
      drive(0, 1, 0, 0, 0, 1, 32'h30, 32'hA5A50030);
      run(1);
      mdl_do(1, 1, 32'h30, 32'hA5A50030);
      drive(1, 0, 1, 32'h30, 32'h55, 0, 0, 0);
      @(negedge clk);
      @(posedge clk); #1;
      bus.r0_req = 1'b0;
      @(negedge clk);
      total++; if (bus.dm_memwrite !== 1'b1) begin bad++; $display("FAIL rsta_pre got=%b exp=1", bus.dm_memwrite); end
      #1 reset = 1'b0;
      #1;
      mdl_reset();
      total++; if ({bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.dm_memwrite, bus.dm_memread} !== 6'b0) begin bad++; $display("FAIL rsta_ctrl got=%b exp=000000", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.dm_memwrite, bus.dm_memread}); end
      total++; if ({bus.r0_rdata, bus.r1_rdata, bus.dm_addr, bus.dm_invalue} !== 128'h0) begin bad++; $display("FAIL rsta_data got=%h exp=0", {bus.r0_rdata, bus.r1_rdata, bus.dm_addr, bus.dm_invalue}); end
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      drive(1, 0, 0, 32'h30, 32'h0, 0, 0, 0);
      run(1);
      mdl_do(0, 0, 32'h30, 32'h0);
      total++; if ({o_rv0, o_rd0} !== {1'b1, 32'hA5A50030}) begin bad++; $display("FAIL rsta_noncommit got=%b %h exp=1 a5a50030", o_rv0, o_rd0); end
   endtask
   task automatic test_reset_resp();
      drive(0, 1, 0, 0, 0, 1, 32'h34, 32'hC0DE0034);
      @(negedge clk);
      @(posedge clk); #1;
      bus.r1_req = 1'b0;
      @(posedge clk); #1;
      mdl_do(1, 1, 32'h34, 32'hC0DE0034);
      @(negedge clk);
      total++; if (bus.r1_rvalid !== 1'b1) begin bad++; $display("FAIL rstr_pre got=%b exp=1", bus.r1_rvalid); end
      #1 reset = 1'b0;
      #1;
      mdl_reset();
      total++; if ({bus.r0_rvalid, bus.r1_rvalid, bus.r1_rdata} !== 34'h0) begin bad++; $display("FAIL rstr_drop got=%b%b %h exp=00 0", bus.r0_rvalid, bus.r1_rvalid, bus.r1_rdata); end
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      drive(1, 0, 0, 32'h34, 32'h0, 0, 0, 0);
      run(1);
      mdl_do(0, 0, 32'h34, 32'h0);
      total++; if (o_rd0 !== 32'hC0DE0034) begin bad++; $display("FAIL rstr_commit got=%h exp=c0de0034", o_rd0); end
   endtask
   initial begin
      test_reset();
      test_idle();
      test_write_read();
      test_r1_read();
      test_held();
      test_pulse();
      test_random(40);
      test_reset_access();
      test_reset_resp();
      test_held();
      test_random(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
